// File: rtl/slice_rr_scheduler_if.sv
// Requester-side and encoder-side handshake bundle of the slice scheduler.
// master is the scheduler; slave is whatever sits on the other side (sources plus encoder).
interface slice_rr_scheduler_if #(
    parameter int NREQ = 4,
    parameter int PIXW = 10
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*PIXW-1:0] req_px;
    logic [NREQ-1:0]      req_ready;
    logic                 enc_valid;
    logic [PIXW-1:0]      enc_px;
    logic                 enc_first;
    logic                 enc_last;
    logic                 enc_ready;

    modport master (
        input  req_valid, req_px, enc_ready,
        output req_ready, enc_valid, enc_px, enc_first, enc_last
    );

    modport slave (
        output req_valid, req_px, enc_ready,
        input  req_ready, enc_valid, enc_px, enc_first, enc_last
    );
endinterface

// File: rtl/slice_rr_scheduler.sv
// Round-robin slice scheduler: grants one requester per slice of SLICE_PX pixels to the
// encoder lane and throttles the feed with rate-buffer hysteresis.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | scan req_valid from rr_ptr, one cycle per slice
// S_STREAM | feed grantee pixels until SLICE_PX have been accepted
module slice_rr_scheduler #(
    parameter int NREQ     = 4,
    parameter int PIXW     = 10,
    parameter int SLICE_PX = 8,
    parameter int LVLW     = 12,
    parameter int BUF_HI   = 3072,
    parameter int BUF_LO   = 2048
) (
    input  logic                      clk,
    input  logic                      rstn,
    slice_rr_scheduler_if.master      bus,
    input  logic [LVLW-1:0]           buf_level,
    output logic [$clog2(NREQ)-1:0]   gnt_id,
    output logic                      busy,
    output logic                      throttled,
    output logic                      slice_done,
    output logic [$clog2(NREQ)-1:0]   done_id
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(SLICE_PX);
    localparam logic [CW-1:0] LAST_PX = CW'(SLICE_PX - 1);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    logic [0:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic [CW-1:0]  px_cnt;
    logic           win_found;
    logic [IDW-1:0] win_id;
    logic           streaming;
    logic           accept;
    int             scan_idx;

    // Walk offsets from high to low so the lowest offset from rr_ptr wins last.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            scan_idx = int'(rr_ptr) + i;
            if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
            if (bus.req_valid[IDW'(scan_idx)]) begin
                win_found = 1'b1;
                win_id    = IDW'(scan_idx);
            end
        end
    end

    assign streaming     = (state == S_STREAM);
    assign busy          = streaming;
    assign bus.enc_valid = streaming && bus.req_valid[gnt_id] && !throttled;
    assign bus.enc_px    = bus.req_px[gnt_id*PIXW +: PIXW];
    assign bus.enc_first = streaming && (px_cnt == '0);
    assign bus.enc_last  = streaming && (px_cnt == LAST_PX);
    assign accept        = bus.enc_valid && bus.enc_ready;

    always_comb begin
        bus.req_ready = '0;
        if (streaming && bus.enc_ready && !throttled) bus.req_ready[gnt_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            gnt_id     <= '0;
            px_cnt     <= '0;
            throttled  <= 1'b0;
            slice_done <= 1'b0;
            done_id    <= '0;
        end else begin
            // Between the thresholds the throttle holds its previous value.
            if (buf_level >= LVLW'(BUF_HI))      throttled <= 1'b1;
            else if (buf_level <= LVLW'(BUF_LO)) throttled <= 1'b0;

            slice_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        gnt_id <= win_id;
                        px_cnt <= '0;
                        state  <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (accept) begin
                        if (px_cnt == LAST_PX) begin
                            state      <= S_IDLE;
                            rr_ptr     <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
                            slice_done <= 1'b1;
                            done_id    <= gnt_id;
                        end else begin
                            px_cnt <= px_cnt + CW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_slice_rr_scheduler.sv
// Directed bench for slice_rr_scheduler: round-robin order, grant hold, throttle
// hysteresis, randomised handshakes, mid-slice reset, and a 3-requester build.
module tb_slice_rr_scheduler;
    logic        clk;
    logic        rstn;
    logic        rstn3;
    logic [11:0] buf_level;
    logic [11:0] buf_level3;
    logic [1:0]  gnt_id, done_id, gnt_id3, done_id3;
    logic        busy, throttled, slice_done;
    logic        busy3, throttled3, slice_done3;

    int checks = 0;
    int errors = 0;
    int px_idx [4];
    int sb_cnt = 0;

    slice_rr_scheduler_if #(.NREQ(4), .PIXW(10)) bus ();
    slice_rr_scheduler_if #(.NREQ(3), .PIXW(10)) bus3 ();

    slice_rr_scheduler #(
        .NREQ(4), .PIXW(10), .SLICE_PX(8), .LVLW(12), .BUF_HI(3072), .BUF_LO(2048)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(bus), .buf_level(buf_level),
        .gnt_id(gnt_id), .busy(busy), .throttled(throttled),
        .slice_done(slice_done), .done_id(done_id)
    );

    slice_rr_scheduler #(
        .NREQ(3), .PIXW(10), .SLICE_PX(8), .LVLW(12), .BUF_HI(3072), .BUF_LO(2048)
    ) dut3 (
        .clk(clk), .rstn(rstn3), .bus(bus3), .buf_level(buf_level3),
        .gnt_id(gnt_id3), .busy(busy3), .throttled(throttled3),
        .slice_done(slice_done3), .done_id(done_id3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] pix(input int i, input int n);
        return 10'((i << 8) | (n & 255));
    endfunction

    // Called at a negedge: drive source pixels, score the upcoming edge, advance one cycle.
    task automatic step();
        logic       acc;
        logic [3:0] exp_rdy;
        int         g;
        for (int i = 0; i < 4; i++) bus.req_px[i*10 +: 10] = pix(i, px_idx[i]);
        #1;
        g   = int'(gnt_id);
        acc = bus.enc_valid && bus.enc_ready;
        if (rstn) begin
            exp_rdy = (busy && bus.enc_ready && !throttled) ? (4'b0001 << g) : 4'b0000;
            chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
            if (acc) begin
                chk("enc_px", 32'(bus.enc_px), 32'(pix(g, px_idx[g])));
                chk("enc_first", 32'(bus.enc_first), 32'(sb_cnt == 0));
                chk("enc_last", 32'(bus.enc_last), 32'(sb_cnt == 7));
                sb_cnt = (sb_cnt == 7) ? 0 : sb_cnt + 1;
                px_idx[g]++;
            end
        end else begin
            sb_cnt = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int done_cnt;
        int cyc;
        for (int i = 0; i < 4; i++) px_idx[i] = 0;
        rstn          = 1'b0;
        rstn3         = 1'b0;
        buf_level     = '0;
        buf_level3    = '0;
        bus.req_valid = '0;
        bus.req_px    = '0;
        bus.enc_ready = 1'b0;
        bus3.req_valid = 3'b111;
        bus3.req_px    = '0;
        bus3.enc_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", 32'(busy), 0);
        chk("rst_enc_valid", 32'(bus.enc_valid), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_gnt", 32'(gnt_id), 0);
        chk("rst_throttled", 32'(throttled), 0);
        chk("rst_slice_done", 32'(slice_done), 0);
        chk("rst_done_id", 32'(done_id), 0);
        chk("rst_first", 32'(bus.enc_first), 0);
        chk("rst_last", 32'(bus.enc_last), 0);

        // 1: all valid, grants 0,1,2,3,0 with one idle cycle between slices
        rstn          = 1'b1;
        bus.req_valid = 4'b1111;
        bus.enc_ready = 1'b1;
        for (int s = 0; s < 5; s++) begin
            chk("t1_idle", 32'(busy), 0);
            if (s > 0) begin
                chk("t1_done", 32'(slice_done), 1);
                chk("t1_done_id", 32'(done_id), 32'(s - 1));
            end
            step();
            chk("t1_gnt", 32'(gnt_id), 32'(s % 4));
            chk("t1_busy", 32'(busy), 1);
            chk("t1_done_clr", 32'(slice_done), 0);
            for (int k = 0; k < 8; k++) begin
                chk("t1_valid", 32'(bus.enc_valid), 1);
                step();
            end
        end
        chk("t1_done_last", 32'(slice_done), 1);
        chk("t1_done_id_last", 32'(done_id), 0);

        // 2: only req 2, req 1 raised mid-slice; no preemption, next grant wraps to 1
        bus.req_valid = 4'b0100;
        step();
        chk("t2_gnt2", 32'(gnt_id), 2);
        repeat (3) step();
        bus.req_valid = 4'b0110;
        for (int k = 0; k < 5; k++) begin
            chk("t2_hold_gnt", 32'(gnt_id), 2);
            chk("t2_rdy1", 32'(bus.req_ready[1]), 0);
            step();
        end
        chk("t2_done", 32'(slice_done), 1);
        chk("t2_done_id", 32'(done_id), 2);
        step();
        chk("t2_gnt1", 32'(gnt_id), 1);

        // 3: throttle hysteresis mid-slice at px_cnt 3
        repeat (3) step();
        bus.enc_ready = 1'b0;
        buf_level     = 12'd3072;
        step();
        chk("t3_thr_on", 32'(throttled), 1);
        chk("t3_valid_off", 32'(bus.enc_valid), 0);
        bus.enc_ready = 1'b1;
        buf_level     = 12'd2500;
        step();
        chk("t3_thr_hold", 32'(throttled), 1);
        chk("t3_valid_hold", 32'(bus.enc_valid), 0);
        chk("t3_rdy_hold", 32'(bus.req_ready), 0);
        buf_level = 12'd2048;
        step();
        chk("t3_thr_off", 32'(throttled), 0);
        chk("t3_valid_on", 32'(bus.enc_valid), 1);
        chk("t3_first_off", 32'(bus.enc_first), 0);
        chk("t3_busy", 32'(busy), 1);
        repeat (5) step();
        chk("t3_done", 32'(slice_done), 1);
        chk("t3_done_id", 32'(done_id), 1);

        // 4: random enc_ready and gapped req 3 for two slices
        buf_level = '0;
        done_cnt  = 0;
        cyc       = 0;
        while (done_cnt < 2 && cyc < 400) begin
            bus.enc_ready = 1'($urandom_range(0, 1));
            bus.req_valid = {($urandom_range(0, 3) != 0), 3'b000};
            step();
            if (slice_done) begin
                done_cnt++;
                chk("t4_done_id", 32'(done_id), 3);
            end
            cyc++;
        end
        chk("t4_slices", 32'(done_cnt), 2);
        chk("t4_scored", 32'(sb_cnt), 0);

        // 5: reset at px_cnt 5 of a req 1 slice; rr_ptr returns to 0
        bus.req_valid = 4'b0010;
        bus.enc_ready = 1'b1;
        step();
        chk("t5_gnt1a", 32'(gnt_id), 1);
        repeat (8) step();
        chk("t5_done_a", 32'(slice_done), 1);
        step();
        chk("t5_gnt1b", 32'(gnt_id), 1);
        repeat (5) step();
        rstn = 1'b0;
        step();
        chk("t5_busy", 32'(busy), 0);
        chk("t5_valid", 32'(bus.enc_valid), 0);
        chk("t5_no_done", 32'(slice_done), 0);
        chk("t5_last", 32'(bus.enc_last), 0);
        rstn          = 1'b1;
        bus.req_valid = 4'b1111;
        step();
        chk("t5_no_done2", 32'(slice_done), 0);
        chk("t5_gnt0", 32'(gnt_id), 0);
        chk("t5_busy2", 32'(busy), 1);

        // 6: three-requester build wraps 0,1,2,0
        rstn3 = 1'b1;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            chk("t6_gnt", 32'(gnt_id3), 32'(s % 3));
            chk("t6_busy", 32'(busy3), 1);
            repeat (8) @(negedge clk);
            chk("t6_done", 32'(slice_done3), 1);
            chk("t6_done_id", 32'(done_id3), 32'(s % 3));
        end
        chk("t6_thr", 32'(throttled3), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/slice_rr_scheduler.md
Name: slice_rr_scheduler

Overview:
- Time-shares one delta/RLE encoder lane between NREQ slice sources, e.g. per-slice line fetchers of the display controller.
- Grants one requester for a whole slice of SLICE_PX pixels, round-robin, and marks slice boundaries to the encoder.
- Throttles the encoder feed with hysteresis using the downstream rate-buffer occupancy, so the link-side buffer cannot overflow during compression transients.

Parameters:
NREQ, 4, number of slice requesters (2..16)
PIXW, 10, pixel width in bits
SLICE_PX, 8, pixels per slice (>=2)
LVLW, 12, width of buffer-level input
BUF_HI, 3072, occupancy at or above which feed is throttled
BUF_LO, 2048, occupancy at or below which throttle releases (BUF_LO < BUF_HI)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
req_valid  in  NREQ  per-requester pixel valid
req_px  in  NREQ*PIXW  per-requester pixel; requester i occupies bits [i*PIXW +: PIXW]
req_ready  out  NREQ  per-requester pixel accept
enc_valid  out  1  pixel valid to encoder
enc_px  out  PIXW  pixel to encoder
enc_first  out  1  qualifies enc_valid: first pixel of a slice
enc_last  out  1  qualifies enc_valid: last pixel of a slice
enc_ready  in  1  encoder accept
buf_level  in  LVLW  rate-buffer occupancy in words
gnt_id  out  clog2(NREQ)  current grantee index
busy  out  1  a slice is in progress
throttled  out  1  hysteresis throttle active
slice_done  out  1  one-cycle pulse after the last pixel of a slice is accepted
done_id  out  clog2(NREQ)  grantee of the completed slice, valid with slice_done

Behaviour:
- Reset (rstn=0 at posedge), all registered state cleared:
  - state=IDLE, rr_ptr=0, gnt_id=0, px_cnt=0, throttled=0, slice_done=0, done_id=0.
  - Combinational outputs follow from that state: busy=0, enc_valid=0, req_ready=0, enc_first=0, enc_last=0. enc_px is a don't-care while enc_valid=0.
  - Reset mid-slice abandons the slice; no enc_last or slice_done is issued.
- States:
  - IDLE: scan req_valid starting at rr_ptr, upward with wrap. The first set bit is the winner.
  - On a winner: gnt_id<=winner, px_cnt<=0, state<=STREAM. No winner: stay IDLE.
  - IDLE always costs exactly one cycle per slice, so there is a one-cycle bubble between back-to-back slices.
  - STREAM: feed pixels. Accept when enc_valid && enc_ready.
  - On accept with px_cnt==SLICE_PX-1: state<=IDLE, rr_ptr<=(gnt_id+1) mod NREQ, slice_done<=1, done_id<=gnt_id.
  - On any other accept: px_cnt<=px_cnt+1.
  - The requester keeps the grant for the whole slice. There is no preemption; if req_valid of the grantee drops, STREAM simply waits.
- Datapath, combinational in STREAM:
  - enc_valid = req_valid[gnt_id] && !throttled.
  - enc_px = req_px slice of gnt_id.
  - req_ready[gnt_id] = enc_ready && !throttled; all other req_ready=0.
  - enc_first = (px_cnt==0); enc_last = (px_cnt==SLICE_PX-1).
  - In IDLE: enc_valid=0, all req_ready=0. busy=(state==STREAM).
- Throttle, registered, evaluated every cycle in every state:
  - if buf_level>=BUF_HI then throttled<=1;
  - else if buf_level<=BUF_LO then throttled<=0;
  - otherwise hold.
  - Throttle changes the cycle after the level crosses a threshold. It never splits the grant and never resets px_cnt.
- slice_done is high exactly one cycle. A new slice may start in the same cycle slice_done is high (IDLE overlaps the pulse).
- Width rules:
  - px_cnt width is clog2(SLICE_PX) and never wraps past SLICE_PX-1.
  - rr_ptr wrap uses an explicit compare to NREQ-1, so non-power-of-two NREQ is valid.
- Fairness: with all requesters continuously valid, grants follow 0,1,..,NREQ-1,0,... Starvation is impossible within NREQ slices.

Test Plan:
1. Reset then all req_valid=4'b1111, enc_ready=1, buf_level=0 -> grants 0,1,2,3,0 in order. Each slice is 8 accepted pixels with enc_first on pixel 0 and enc_last on pixel 7. slice_done pulses with done_id 0,1,2,3. Exactly one idle cycle between slices.
2. Only req 2 valid, then req 1 raised mid-slice of 2 -> slice 2 completes uninterrupted; next grant is 1 after wrap (3,0 not valid). req_ready[1] stays 0 during slice 2.
3. Mid-slice at px_cnt=3, buf_level=3072 -> throttled=1 next cycle and enc_valid=0. buf_level=2500 -> stays throttled. buf_level=2048 -> releases. Streaming resumes at px_cnt=3 with no pixel lost or duplicated.
4. enc_ready toggled randomly and grantee req_valid gapped -> the px sequence at the encoder equals the requester's sequence exactly. enc_last aligns with the 8th accepted pixel. No acceptance occurs when enc_valid && enc_ready is false.
5. rstn=0 at px_cnt=5 of slice for req 1 -> next cycle enc_valid=0, busy=0, no slice_done. After release, the first grant scans from 0.
6. NREQ=3 build, all valid -> grant order 0,1,2,0 (rr_ptr wraps correctly at a non-power-of-two size).
